// File: rtl/pooling_channel_scheduler_pkg.sv
// Shared types and size helpers for the pooling channel scheduler.
package pool_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FEED  = 3'd1,
        S_DRAIN = 3'd2,
        S_SQZ   = 3'd3,
        S_NEXT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // PIX_NUM: pixels per channel.
    function automatic int pix_num(input int w, input int h);
        return w * h;
    endfunction

    // PIX_CNT_W: width of the per-channel pixel counter, never below 1.
    function automatic int pix_cnt_w(input int w, input int h);
        return (w * h > 1) ? $clog2(w * h) : 1;
    endfunction

endpackage

// File: rtl/pooling_channel_scheduler_rd_pipe.sv
// Valid delay line matching the feature-RAM read latency; EMPTY means no read in flight.
module pool_sched_rd_pipe #(
    parameter int STAGES = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic RD_EN,
    output logic DIN_VALID,
    output logic EMPTY
);

    logic [STAGES-1:0] vld_p0;

    generate
        if (STAGES == 1) begin : g_one
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) vld_p0 <= '0;
                else     vld_p0 <= RD_EN;
            end
        end else begin : g_many
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) vld_p0 <= '0;
                else     vld_p0 <= {vld_p0[STAGES-2:0], RD_EN};
            end
        end
    endgenerate

    assign DIN_VALID = vld_p0[STAGES-1];
    assign EMPTY     = (vld_p0 == '0);

endmodule

// File: rtl/pooling_channel_scheduler.sv
// Streams each channel of a feature map through the pooling core, then squeezes it out.
// Optional busy-cycle counter enabled by defining POOL_SCHED_PERF_CNT_EN.
module pooling_channel_scheduler
    import pool_sched_pkg::*;
#(
    parameter int P_WIDTH   = 16,
    parameter int P_HEIGHT  = 16,
    parameter int P_CH_W    = 3,
    parameter int P_ADDR_W  = 12,
    parameter int DW        = 24,
    parameter int P_RD_LAT  = 1,
    parameter int P_SQZ_MAX = 2 * P_WIDTH + 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                START,
    input  logic [P_CH_W:0]     CFG_CH_NUM,
    input  logic                HOLD,
    output logic                BUSY,
    output logic                DONE,
    output logic                ERR,
    output logic [P_CH_W-1:0]   CH_IDX,
    output logic                RD_EN,
    output logic [P_ADDR_W-1:0] RD_ADDR,
    input  logic [DW-1:0]       RD_DATA,
    output logic                POOL_DIN_VALID,
    output logic [DW-1:0]       POOL_DIN,
    output logic                POOL_SQUEEZE,
    output logic                POOL_NEXT_CH,
    input  logic                POOL_LAST_PIX,
    output logic [31:0]         PERF_CYCLES
);

    localparam int PIX_NUM   = pix_num(P_WIDTH, P_HEIGHT);
    localparam int PIX_CNT_W = pix_cnt_w(P_WIDTH, P_HEIGHT);
    localparam int SQZ_W     = $clog2(P_SQZ_MAX + 1);
    localparam int CH_MAX    = 2 ** P_CH_W;

    state_t                state;
    logic [PIX_CNT_W-1:0]  pix;
    logic [SQZ_W-1:0]      sqz_cnt;
    logic [P_ADDR_W-1:0]   base;
    logic [P_CH_W:0]       ch_num;
    logic [P_CH_W-1:0]     ch_idx;
    logic                  err_r;
    logic                  done_r;
    logic                  pipe_empty;
    logic                  sqz_lim;
    logic                  last_ch;
    logic [P_CH_W:0]       cfg_clamped;

    assign cfg_clamped = (CFG_CH_NUM > (P_CH_W+1)'(CH_MAX)) ? (P_CH_W+1)'(CH_MAX) : CFG_CH_NUM;
    assign sqz_lim     = (sqz_cnt == SQZ_W'(P_SQZ_MAX));
    assign last_ch     = ({1'b0, ch_idx} == (ch_num - (P_CH_W+1)'(1)));

    assign RD_EN          = (state == S_FEED) && !HOLD;
    assign RD_ADDR        = RD_EN ? (base + P_ADDR_W'(pix)) : '0;
    assign POOL_SQUEEZE   = (state == S_SQZ) && !HOLD && !sqz_lim;
    assign POOL_NEXT_CH   = (state == S_NEXT);
    assign BUSY           = (state == S_FEED) || (state == S_DRAIN) ||
                            (state == S_SQZ)  || (state == S_NEXT);
    assign DONE           = done_r;
    assign ERR            = err_r;
    assign CH_IDX         = ch_idx;
    assign POOL_DIN       = RD_DATA;

    pool_sched_rd_pipe #(
        .STAGES (P_RD_LAT)
    ) u_rd_pipe (
        .CLK       (CLK),
        .RST       (RST),
        .RD_EN     (RD_EN),
        .DIN_VALID (POOL_DIN_VALID),
        .EMPTY     (pipe_empty)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= S_IDLE;
            pix     <= '0;
            sqz_cnt <= '0;
            base    <= '0;
            ch_num  <= '0;
            ch_idx  <= '0;
            err_r   <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            // DONE is registered out of the DONE state, so it lands as IDLE resumes
            done_r <= (state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (START) begin
                        err_r   <= 1'b0;
                        base    <= '0;
                        ch_idx  <= '0;
                        pix     <= '0;
                        sqz_cnt <= '0;
                        ch_num  <= cfg_clamped;
                        state   <= (CFG_CH_NUM == '0) ? S_DONE : S_FEED;
                    end
                end
                S_FEED: begin
                    if (POOL_LAST_PIX) err_r <= 1'b1;
                    if (!HOLD) begin
                        pix <= pix + PIX_CNT_W'(1);
                        if (pix == PIX_CNT_W'(PIX_NUM - 1)) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (POOL_LAST_PIX) err_r <= 1'b1;
                    if (pipe_empty) state <= S_SQZ;
                end
                S_SQZ: begin
                    if (POOL_LAST_PIX) begin
                        state <= S_NEXT;
                    end else if (sqz_lim) begin
                        err_r <= 1'b1;
                        state <= S_NEXT;
                    end else if (!HOLD) begin
                        sqz_cnt <= sqz_cnt + SQZ_W'(1);
                    end
                end
                S_NEXT: begin
                    base    <= base + P_ADDR_W'(PIX_NUM);
                    pix     <= '0;
                    sqz_cnt <= '0;
                    if (last_ch) begin
                        state <= S_DONE;
                    end else begin
                        ch_idx <= ch_idx + P_CH_W'(1);
                        state  <= S_FEED;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef POOL_SCHED_PERF_CNT_EN
    logic [31:0] perf_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            perf_cnt <= '0;
        end else if ((state == S_IDLE) && START) begin
            perf_cnt <= '0;
        end else if (BUSY && (perf_cnt != 32'hFFFF_FFFF)) begin
            perf_cnt <= perf_cnt + 32'd1;
        end
    end

    assign PERF_CYCLES = perf_cnt;
`else
    assign PERF_CYCLES = '0;
`endif

endmodule

// File: tb/tb_pooling_channel_scheduler.sv
// Scoreboard bench for pooling_channel_scheduler with a RAM model and a 2x2 max-pool core stub.
module tb_pooling_channel_scheduler;

    localparam int P_WIDTH  = 4;
    localparam int P_HEIGHT = 4;
    localparam int P_CH_W   = 3;
    localparam int P_ADDR_W = 12;
    localparam int DW       = 24;
    localparam int P_RD_LAT = 1;
    localparam int P_SQZ_MAX = 2 * P_WIDTH + 4;

    logic                CLK = 1'b0;
    logic                RST = 1'b1;
    logic                START = 1'b0;
    logic [P_CH_W:0]     CFG_CH_NUM = '0;
    logic                HOLD = 1'b0;
    logic                BUSY, DONE, ERR;
    logic [P_CH_W-1:0]   CH_IDX;
    logic                RD_EN;
    logic [P_ADDR_W-1:0] RD_ADDR;
    logic [DW-1:0]       RD_DATA = '0;
    logic                POOL_DIN_VALID;
    logic [DW-1:0]       POOL_DIN;
    logic                POOL_SQUEEZE;
    logic                POOL_NEXT_CH;
    logic                POOL_LAST_PIX;
    logic [31:0]         PERF_CYCLES;

    int compared = 0;
    int mismatched = 0;

    int exp_addr_q[$];
    logic [DW-1:0] exp_din_q[$];
    logic [DW-1:0] exp_pool_q[$];

    int rd_cnt = 0, next_cnt = 0, sqz_cnt = 0, busy_cnt = 0, pool_cnt = 0;

    // core stub state
    logic [DW-1:0] img [16];
    int            cpix;
    int            csqz;
    logic          core_last;
    logic          pool_vld;
    logic [DW-1:0] pool_out;
    logic          force_low = 1'b0;

    pooling_channel_scheduler #(
        .P_WIDTH   (P_WIDTH),
        .P_HEIGHT  (P_HEIGHT),
        .P_CH_W    (P_CH_W),
        .P_ADDR_W  (P_ADDR_W),
        .DW        (DW),
        .P_RD_LAT  (P_RD_LAT),
        .P_SQZ_MAX (P_SQZ_MAX)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .START          (START),
        .CFG_CH_NUM     (CFG_CH_NUM),
        .HOLD           (HOLD),
        .BUSY           (BUSY),
        .DONE           (DONE),
        .ERR            (ERR),
        .CH_IDX         (CH_IDX),
        .RD_EN          (RD_EN),
        .RD_ADDR        (RD_ADDR),
        .RD_DATA        (RD_DATA),
        .POOL_DIN_VALID (POOL_DIN_VALID),
        .POOL_DIN       (POOL_DIN),
        .POOL_SQUEEZE   (POOL_SQUEEZE),
        .POOL_NEXT_CH   (POOL_NEXT_CH),
        .POOL_LAST_PIX  (POOL_LAST_PIX)
        ,.PERF_CYCLES   (PERF_CYCLES)
    );

    always #5 CLK = ~CLK;

    function automatic logic [DW-1:0] ram_val(input int a);
        logic [DW-1:0] t;
        t = DW'(a & 12'hFFF) * 24'd40503;
        return t ^ 24'h05A3C1;
    endfunction

    function automatic logic [DW-1:0] max2(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    always @(posedge CLK) begin
        if (RD_EN) RD_DATA <= ram_val(int'(RD_ADDR));
    end

    assign POOL_LAST_PIX = core_last;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            cpix      <= 0;
            csqz      <= 0;
            core_last <= 1'b0;
            pool_vld  <= 1'b0;
            pool_out  <= '0;
        end else begin
            pool_vld <= 1'b0;
            if (POOL_NEXT_CH) begin
                cpix      <= 0;
                csqz      <= 0;
                core_last <= 1'b0;
            end else begin
                if (POOL_DIN_VALID && cpix < 16) begin
                    img[cpix] <= POOL_DIN;
                    cpix      <= cpix + 1;
                    if (((cpix / 4) % 2 == 1) && ((cpix % 4) % 2 == 1)) begin
                        pool_out <= max2(max2(POOL_DIN, img[cpix-1]), max2(img[cpix-4], img[cpix-5]));
                        pool_vld <= 1'b1;
                    end
                end
                if (POOL_SQUEEZE) begin
                    csqz      <= csqz + 1;
                    core_last <= (csqz + 1 >= 3) && !force_low;
                end
            end
        end
    end

    // scoreboard monitor, sampled mid-cycle
    always @(negedge CLK) begin
        if (!RST) begin
            if (RD_EN) begin
                rd_cnt++;
                compared++;
                if (exp_addr_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL rd_addr: unexpected read of %0d, none required", RD_ADDR);
                end else begin
                    int e;
                    e = exp_addr_q.pop_front();
                    if (RD_ADDR !== P_ADDR_W'(e) || CH_IDX !== P_CH_W'((e >> 4) & 7)) begin
                        mismatched++;
                        $display("FAIL rd_addr: got addr %0d ch %0d, required addr %0d ch %0d",
                                 RD_ADDR, CH_IDX, e, (e >> 4) & 7);
                    end
                end
            end
            if (POOL_DIN_VALID) begin
                compared++;
                if (exp_din_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL pool_din: unexpected valid with %h", POOL_DIN);
                end else begin
                    logic [DW-1:0] d;
                    d = exp_din_q.pop_front();
                    if (POOL_DIN !== d) begin
                        mismatched++;
                        $display("FAIL pool_din: got %h, required %h", POOL_DIN, d);
                    end
                end
            end
            if (pool_vld) begin
                pool_cnt++;
                compared++;
                if (exp_pool_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL pooled: unexpected output %h", pool_out);
                end else begin
                    logic [DW-1:0] p;
                    p = exp_pool_q.pop_front();
                    if (pool_out !== p) begin
                        mismatched++;
                        $display("FAIL pooled: got %h, required %h", pool_out, p);
                    end
                end
            end
            if (POOL_NEXT_CH) next_cnt++;
            if (POOL_SQUEEZE) sqz_cnt++;
            if (BUSY) busy_cnt++;
        end
    end

    task automatic push_run(input int nch);
        int b;
        for (int ch = 0; ch < nch; ch++) begin
            b = ch * 16;
            for (int p = 0; p < 16; p++) begin
                exp_addr_q.push_back(b + p);
                exp_din_q.push_back(ram_val(b + p));
            end
            for (int r = 1; r < 4; r += 2) begin
                for (int c = 1; c < 4; c += 2) begin
                    int i;
                    i = b + r * 4 + c;
                    exp_pool_q.push_back(max2(max2(ram_val(i), ram_val(i-1)),
                                              max2(ram_val(i-4), ram_val(i-5))));
                end
            end
        end
    endtask

    task automatic start_run(input logic [P_CH_W:0] n);
        @(posedge CLK);
        #1 CFG_CH_NUM = n;
        START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
    endtask

    task automatic wait_done(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge CLK);
            if (DONE) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        compared++;
        if ({BUSY, DONE, ERR, RD_EN, POOL_DIN_VALID, POOL_SQUEEZE, POOL_NEXT_CH} !== 7'b0) begin
            mismatched++;
            $display("FAIL reset_ctrl: got %b, required 0000000",
                     {BUSY, DONE, ERR, RD_EN, POOL_DIN_VALID, POOL_SQUEEZE, POOL_NEXT_CH});
        end
        compared++;
        if (RD_ADDR !== '0 || CH_IDX !== '0) begin
            mismatched++;
            $display("FAIL reset_addr: got addr %0d ch %0d, required 0 0", RD_ADDR, CH_IDX);
        end
        compared++;
        if (PERF_CYCLES !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_perf: got %0d, required 0", PERF_CYCLES);
        end
        @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    task automatic test_single();
        bit ok;
        int n0;
        n0 = next_cnt;
        push_run(1);
        start_run(1);
        @(negedge CLK);
        compared++;
        if (RD_EN !== 1'b1 || RD_ADDR !== '0 || BUSY !== 1'b1) begin
            mismatched++;
            $display("FAIL first_issue: got rd_en %b addr %0d busy %b, required 1 0 1", RD_EN, RD_ADDR, BUSY);
        end
        // a START while busy must be ignored
        @(posedge CLK);
        #1 CFG_CH_NUM = 3;
        START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        wait_done(200, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL single_done: got no DONE, required DONE within 200 cycles");
        end
        compared++;
        if (ERR !== 1'b0 || next_cnt - n0 !== 1) begin
            mismatched++;
            $display("FAIL single_end: got err %b next %0d, required 0 1", ERR, next_cnt - n0);
        end
    endtask

    task automatic test_multi();
        bit ok;
        int n0, p0, r0;
        n0 = next_cnt; p0 = pool_cnt; r0 = rd_cnt;
        push_run(3);
        start_run(3);
        wait_done(400, ok);
        @(negedge CLK);
        compared++;
        if (!ok || next_cnt - n0 !== 3 || pool_cnt - p0 !== 12 || rd_cnt - r0 !== 48) begin
            mismatched++;
            $display("FAIL multi_counts: got done %b next %0d pooled %0d reads %0d, required 1 3 12 48",
                     ok, next_cnt - n0, pool_cnt - p0, rd_cnt - r0);
        end
        compared++;
        if (CH_IDX !== 3'd2) begin
            mismatched++;
            $display("FAIL multi_chidx: got %0d, required 2", CH_IDX);
        end
    endtask

    task automatic test_hold();
        bit ok, found;
        int p0;
        p0 = pool_cnt;
        found = 1'b0;
        push_run(1);
        start_run(1);
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge CLK);
            if (RD_EN && RD_ADDR == 7) found = 1'b1;
        end
        compared++;
        if (!found) begin
            mismatched++;
            $display("FAIL hold_reach: got no read of addr 7, required one within 50 cycles");
        end
        @(posedge CLK);
        #1 HOLD = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            compared++;
            if (RD_EN !== 1'b0 || (i == 0 && POOL_DIN_VALID !== 1'b1)) begin
                mismatched++;
                $display("FAIL hold_cycle%0d: got rd_en %b din_valid %b, required 0 %b",
                         i, RD_EN, POOL_DIN_VALID, (i == 0));
            end
        end
        @(posedge CLK);
        #1 HOLD = 1'b0;
        wait_done(200, ok);
        compared++;
        if (!ok || pool_cnt - p0 !== 4) begin
            mismatched++;
            $display("FAIL hold_end: got done %b pooled %0d, required 1 4", ok, pool_cnt - p0);
        end
    endtask

    task automatic test_watchdog();
        bit ok;
        int s0, n0;
        s0 = sqz_cnt; n0 = next_cnt;
        force_low = 1'b1;
        push_run(1);
        start_run(1);
        wait_done(200, ok);
        compared++;
        if (!ok || ERR !== 1'b1 || sqz_cnt - s0 !== P_SQZ_MAX || next_cnt - n0 !== 1) begin
            mismatched++;
            $display("FAIL watchdog: got done %b err %b squeezes %0d next %0d, required 1 1 %0d 1",
                     ok, ERR, sqz_cnt - s0, next_cnt - n0, P_SQZ_MAX);
        end
        force_low = 1'b0;
    endtask

    task automatic test_zero();
        int n, r0, b0;
        r0 = rd_cnt; b0 = busy_cnt;
        n = 0;
        @(posedge CLK);
        #1 CFG_CH_NUM = 0;
        START = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK);
            #1 START = 1'b0;
            n++;
            @(negedge CLK);
            if (DONE) break;
        end
        compared++;
        if (n !== 2 || DONE !== 1'b1) begin
            mismatched++;
            $display("FAIL zero_latency: got %0d cycles done %b, required 2 1", n, DONE);
        end
        compared++;
        if (rd_cnt - r0 !== 0 || busy_cnt - b0 !== 0 || ERR !== 1'b0) begin
            mismatched++;
            $display("FAIL zero_quiet: got reads %0d busy %0d err %b, required 0 0 0",
                     rd_cnt - r0, busy_cnt - b0, ERR);
        end
    endtask

    task automatic test_clamp();
        bit ok;
        int n0, r0;
        n0 = next_cnt; r0 = rd_cnt;
        push_run(8);
        start_run(4'd12);
        wait_done(1500, ok);
        compared++;
        if (!ok || next_cnt - n0 !== 8 || rd_cnt - r0 !== 128) begin
            mismatched++;
            $display("FAIL clamp: got done %b next %0d reads %0d, required 1 8 128",
                     ok, next_cnt - n0, rd_cnt - r0);
        end
    endtask

    task automatic test_rst_mid();
        bit ok, found;
        int b0;
        found = 1'b0;
        push_run(2);
        start_run(2);
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge CLK);
            if (RD_EN && CH_IDX == 1) found = 1'b1;
        end
        #2 RST = 1'b1;
        #1;
        compared++;
        if (!found || {BUSY, DONE, ERR, RD_EN, POOL_DIN_VALID, POOL_SQUEEZE, POOL_NEXT_CH} !== 7'b0 ||
            RD_ADDR !== '0 || CH_IDX !== '0 || PERF_CYCLES !== 32'd0) begin
            mismatched++;
            $display("FAIL rst_mid: got found %b ctrl %b addr %0d ch %0d perf %0d, required 1 0000000 0 0 0",
                     found, {BUSY, DONE, ERR, RD_EN, POOL_DIN_VALID, POOL_SQUEEZE, POOL_NEXT_CH},
                     RD_ADDR, CH_IDX, PERF_CYCLES);
        end
        exp_addr_q.delete();
        exp_din_q.delete();
        exp_pool_q.delete();
        @(posedge CLK);
        #1 RST = 1'b0;
        push_run(1);
        b0 = busy_cnt;
        start_run(1);
        wait_done(200, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL rst_restart: got no DONE, required DONE within 200 cycles");
        end
        compared++;
`ifdef POOL_SCHED_PERF_CNT_EN
        if (PERF_CYCLES !== 32'(busy_cnt - b0)) begin
            mismatched++;
            $display("FAIL perf: got %0d, required %0d", PERF_CYCLES, busy_cnt - b0);
        end
`else
        if (PERF_CYCLES !== 32'd0) begin
            mismatched++;
            $display("FAIL perf: got %0d, required 0", PERF_CYCLES);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_hold();
        test_watchdog();
        test_zero();
        test_clamp();
        test_rst_mid();
        repeat (3) @(negedge CLK);
        compared++;
        if (exp_addr_q.size() != 0 || exp_din_q.size() != 0 || exp_pool_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain_queues: got %0d/%0d/%0d left, required 0/0/0",
                     exp_addr_q.size(), exp_din_q.size(), exp_pool_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
